// File: rtl/vc_dest_arbiter_pkg.sv
// vc_dest_arbiter_pkg
//  Shared definitions for the VC-to-destination arbiter slice.
//  - arb_state_t : FSM encoding of the arbiter (IDLE / ACTIVE / STALL)
//  - VC*_IDX     : source virtual-channel index held in the pipeline register
//  - DEST_D*     : value of the destination bit that selects D0 or D1
//  - WCNT_W      : width of the VC0 weight counter (VC0_WEIGHT range 1..7)
package vc_dest_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } arb_state_t;

    localparam logic VC0_IDX = 1'b0;
    localparam logic VC1_IDX = 1'b1;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    localparam int WCNT_W = 3;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// vc_dest_arbiter_if
//  Bundles the VC-FIFO read side, the destination-FIFO write side and the
//  arbiter status flags.
//  master : arbiter view (drives pops, pushes, data_D*, idle, error_arb)
//  slave  : environment view (drives init, FIFO flags and VC read data)
interface vc_dest_arbiter_if #(
    parameter int data_width = 6
);
    logic                  init;
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [data_width-1:0] data_out_VC0;
    logic [data_width-1:0] data_out_VC1;
    logic                  almost_full_fifo_D0;
    logic                  almost_full_fifo_D1;
    logic                  full_fifo_D0;
    logic                  full_fifo_D1;
    logic                  pop_VC0;
    logic                  pop_VC1;
    logic                  push_D0;
    logic                  push_D1;
    logic [data_width-1:0] data_D0;
    logic [data_width-1:0] data_D1;
    logic                  idle;
    logic                  error_arb;

    modport master (
        input  init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
        input  almost_full_fifo_D0, almost_full_fifo_D1, full_fifo_D0, full_fifo_D1,
        output pop_VC0, pop_VC1, push_D0, push_D1, data_D0, data_D1, idle, error_arb
    );

    modport slave (
        output init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
        output almost_full_fifo_D0, almost_full_fifo_D1, full_fifo_D0, full_fifo_D1,
        input  pop_VC0, pop_VC1, push_D0, push_D1, data_D0, data_D1, idle, error_arb
    );

endinterface

// File: rtl/vc_dest_arbiter_vc_weight_sel.sv
// vc_weight_sel
//  Weighted grant between VC0 and VC1. VC0 wins while its run of consecutive
//  grants (counted only while VC1 is waiting) is below VC0_WEIGHT; then VC1
//  gets one grant and the run restarts.
//  Ports:
//   clk, reset     clock / async active-high reset
//   i_enable       pops allowed this cycle (ACTIVE, init high, no back-pressure)
//   i_empty_vc0/1  VC FIFO empty flags
//   o_pop_vc0/1    combinational read enables, at most one high
module vc_weight_sel
    import vc_dest_arbiter_pkg::*;
#(
    parameter int VC0_WEIGHT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_empty_vc0,
    input  logic i_empty_vc1,
    output logic o_pop_vc0,
    output logic o_pop_vc1
);

    localparam logic [WCNT_W-1:0] W_LIMIT = WCNT_W'(VC0_WEIGHT);

    logic [WCNT_W-1:0] r_wcnt;
    logic              w_vc0_turn;

    assign w_vc0_turn = i_empty_vc1 | (r_wcnt < W_LIMIT);

    // Grant: VC0 when it has data and it is its turn, otherwise VC1 if it has data.
    always_comb begin
        o_pop_vc0 = 1'b0;
        o_pop_vc1 = 1'b0;
        if (i_enable && !i_empty_vc0 && w_vc0_turn) begin
            o_pop_vc0 = 1'b1;
        end else if (i_enable && !i_empty_vc1) begin
            o_pop_vc1 = 1'b1;
        end else begin
            o_pop_vc0 = 1'b0;
            o_pop_vc1 = 1'b0;
        end
    end

    // Weight counter: counts VC0 grants only while VC1 is competing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= {WCNT_W{1'b0}};
        end else if (i_empty_vc1 || o_pop_vc1) begin
            r_wcnt <= {WCNT_W{1'b0}};
        end else if (o_pop_vc0) begin
            r_wcnt <= r_wcnt + {{(WCNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wcnt <= r_wcnt;
        end
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter
//  Pops words from the VC0/VC1 FIFOs (weighted toward VC0) and writes each word
//  to destination FIFO D0 or D1 chosen by data bit DEST_BIT. Pop in cycle N
//  gives a push in cycle N+2; pops stop while either destination is almost full.
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    vc_dest_arbiter_if.master: init, VC empty flags/read data,
//          destination almost_full/full, pop_VC*, push_D*, data_D*, idle, error_arb
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int data_width = 6,
    parameter int DEST_BIT   = 4,
    parameter int VC0_WEIGHT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    vc_dest_arbiter_if.master      bus
);

    arb_state_t            r_state;
    logic                  r_idle;
    logic                  r_pipe_valid;
    logic                  r_pipe_src;
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [data_width-1:0] r_data_d0;
    logic [data_width-1:0] r_data_d1;
    logic                  r_error;

    logic                  w_almost_full;
    logic                  w_pop_en;
    logic                  w_pop_vc0;
    logic                  w_pop_vc1;
    logic [data_width-1:0] w_pipe_data;

    assign w_almost_full = bus.almost_full_fifo_D0 | bus.almost_full_fifo_D1;
    // init and almost_full gate pops in the same cycle, ahead of the FSM reacting.
    assign w_pop_en      = (r_state == ST_ACTIVE) & bus.init & ~w_almost_full;

    vc_weight_sel #(
        .VC0_WEIGHT (VC0_WEIGHT)
    ) u_weight_sel (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (w_pop_en),
        .i_empty_vc0 (bus.empty_fifo_VC0),
        .i_empty_vc1 (bus.empty_fifo_VC1),
        .o_pop_vc0   (w_pop_vc0),
        .o_pop_vc1   (w_pop_vc1)
    );

    // Read data of the VC popped last cycle.
    always_comb begin
        w_pipe_data = bus.data_out_VC0;
        if (r_pipe_src == VC1_IDX) begin
            w_pipe_data = bus.data_out_VC1;
        end else begin
            w_pipe_data = bus.data_out_VC0;
        end
    end

    // FSM with registered idle; idle looks ahead at the next state and pipe contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.init) begin
                        r_state <= ST_ACTIVE;
                        r_idle  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_idle  <= ~r_pipe_valid;
                    end
                end
                ST_ACTIVE, ST_STALL: begin
                    if (!bus.init) begin
                        r_state <= ST_IDLE;
                        r_idle  <= ~r_pipe_valid;
                    end else if (w_almost_full) begin
                        r_state <= ST_STALL;
                        r_idle  <= 1'b0;
                    end else begin
                        r_state <= ST_ACTIVE;
                        r_idle  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= ~r_pipe_valid;
                end
            endcase
        end
    end

    // Two-stage datapath: remember the popped VC, then route its word to D0/D1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_src   <= VC0_IDX;
            r_push_d0    <= 1'b0;
            r_push_d1    <= 1'b0;
            r_data_d0    <= {data_width{1'b0}};
            r_data_d1    <= {data_width{1'b0}};
        end else begin
            r_pipe_valid <= w_pop_vc0 | w_pop_vc1;
            r_pipe_src   <= w_pop_vc1 ? VC1_IDX : VC0_IDX;
            if (r_pipe_valid && (w_pipe_data[DEST_BIT] == DEST_D1)) begin
                r_push_d0 <= 1'b0;
                r_push_d1 <= 1'b1;
                r_data_d1 <= w_pipe_data;
            end else if (r_pipe_valid) begin
                r_push_d0 <= 1'b1;
                r_push_d1 <= 1'b0;
                r_data_d0 <= w_pipe_data;
            end else begin
                r_push_d0 <= 1'b0;
                r_push_d1 <= 1'b0;
            end
        end
    end

    // Sticky flag: a push landed on a destination that reported full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= r_error | (r_push_d0 & bus.full_fifo_D0) | (r_push_d1 & bus.full_fifo_D1);
        end
    end

    assign bus.pop_VC0   = w_pop_vc0;
    assign bus.pop_VC1   = w_pop_vc1;
    assign bus.push_D0   = r_push_d0;
    assign bus.push_D1   = r_push_d1;
    assign bus.data_D0   = r_data_d0;
    assign bus.data_D1   = r_data_d1;
    assign bus.idle      = r_idle;
    assign bus.error_arb = r_error;

endmodule
